// File: rtl/beep_pattern_sequencer_pkg.sv
// Shared encodings for the beep pattern sequencer and the tone generator it drives.
// State, pattern and frequency-select codes live here so both blocks agree on them.
package beep_pattern_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } state_t;

    localparam logic [1:0] PAT_HIGH  = 2'b00;
    localparam logic [1:0] PAT_LOW   = 2'b01;
    localparam logic [1:0] PAT_ALT_H = 2'b10;
    localparam logic [1:0] PAT_ALT_L = 2'b11;

    localparam logic FREQ_SEL_HIGH = 1'b0;
    localparam logic FREQ_SEL_LOW  = 1'b1;

    // Frequency used for the first beep of a burst.
    function automatic logic initial_freq(input logic [1:0] pat);
        logic f;
        f = FREQ_SEL_HIGH;
        case (pat)
            PAT_HIGH, PAT_ALT_H: f = FREQ_SEL_HIGH;
            PAT_LOW,  PAT_ALT_L: f = FREQ_SEL_LOW;
            default:             f = FREQ_SEL_HIGH;
        endcase
        return f;
    endfunction

    // Whether the frequency flips between consecutive beeps.
    function automatic logic pattern_alternates(input logic [1:0] pat);
        return (pat == PAT_ALT_H) || (pat == PAT_ALT_L);
    endfunction

endpackage

// File: rtl/beep_pattern_sequencer_timer.sv
// Loadable down-counter with a zero flag; times the on and off phases of each beep.
// Load has priority over decrement, and decrement saturates at zero.
module sequencer_timer
    import beep_pattern_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/beep_pattern_sequencer.sv
// Plays a burst of N fixed-length beeps on start, driving the tone generator's
// request, enable and frequency-select inputs. All outputs are registered.
module beep_pattern_sequencer
    import beep_pattern_sequencer_pkg::*;
#(
    parameter int unsigned ON_TICKS  = 25000000,
    parameter int unsigned OFF_TICKS = 12500000,
    parameter int unsigned TIMER_W   = 32,
    parameter int unsigned CNT_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cancel,
    input  logic [CNT_W-1:0] beep_count,
    input  logic [1:0]       pattern,
    output logic             tone_on,
    output logic             tone_en,
    output logic             freq_sel,
    output logic             busy,
    output logic             done
);

    localparam logic [TIMER_W-1:0] ON_RELOAD  = TIMER_W'(ON_TICKS - 1);
    localparam logic [TIMER_W-1:0] OFF_RELOAD = TIMER_W'(OFF_TICKS - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   remaining_q, remaining_d;
    logic               alt_q, alt_d;
    logic               start_ok;

    logic               timer_load;
    logic               timer_dec;
    logic [TIMER_W-1:0] timer_load_val;
    logic               timer_zero;

    logic               tone_on_d, busy_d, freq_sel_d, done_d;

    sequencer_timer #(
        .WIDTH(TIMER_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (timer_load_val),
        .dec      (timer_dec),
        .zero     (timer_zero)
    );

    assign start_ok = start && !cancel && (beep_count != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            alt_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            alt_q       <= alt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        remaining_d    = remaining_q;
        alt_d          = alt_q;
        timer_load     = 1'b0;
        timer_load_val = ON_RELOAD;
        timer_dec      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    state_d        = ST_ON;
                    timer_load     = 1'b1;
                    timer_load_val = ON_RELOAD;
                    remaining_d    = beep_count - CNT_W'(1);
                    alt_d          = pattern_alternates(pattern);
                end
            end
            ST_ON: begin
                if (cancel) begin
                    state_d = ST_IDLE;
                end else if (!timer_zero) begin
                    timer_dec = 1'b1;
                end else if (remaining_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d        = ST_OFF;
                    timer_load     = 1'b1;
                    timer_load_val = OFF_RELOAD;
                end
            end
            ST_OFF: begin
                if (cancel) begin
                    state_d = ST_IDLE;
                end else if (!timer_zero) begin
                    timer_dec = 1'b1;
                end else begin
                    // OFF is only entered with beeps left, so this never underflows.
                    state_d        = ST_ON;
                    timer_load     = 1'b1;
                    timer_load_val = ON_RELOAD;
                    remaining_d    = remaining_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Next-cycle output values, derived from the transition being taken.
    always_comb begin
        tone_on_d  = (state_d == ST_ON);
        busy_d     = (state_d != ST_IDLE);
        done_d     = (state_q == ST_ON) && (state_d == ST_IDLE) && !cancel;
        freq_sel_d = freq_sel;
        if ((state_q == ST_IDLE) && (state_d == ST_ON)) begin
            freq_sel_d = initial_freq(pattern);
        end else if ((state_q == ST_OFF) && (state_d == ST_ON) && alt_q) begin
            freq_sel_d = ~freq_sel;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tone_on  <= 1'b0;
            tone_en  <= 1'b0;
            freq_sel <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            tone_on  <= tone_on_d;
            tone_en  <= busy_d;
            freq_sel <= freq_sel_d;
            busy     <= busy_d;
            done     <= done_d;
        end
    end

endmodule

// File: tb/tb_beep_pattern_sequencer.sv
// Bench for beep_pattern_sequencer: burst scenario table, corner-case sequences and
// random traffic, all checked cycle by cycle against a burst-plan reference model.
module tb_beep_pattern_sequencer;

    localparam int ON  = 4;
    localparam int OFF = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       cancel;
    logic [3:0] beep_count;
    logic [1:0] pattern;
    logic       tone_on, tone_en, freq_sel, busy, done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    beep_pattern_sequencer #(
        .ON_TICKS  (ON),
        .OFF_TICKS (OFF),
        .TIMER_W   (32),
        .CNT_W     (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cancel     (cancel),
        .beep_count (beep_count),
        .pattern    (pattern),
        .tone_on    (tone_on),
        .tone_en    (tone_en),
        .freq_sel   (freq_sel),
        .busy       (busy),
        .done       (done)
    );

    // Reference model: a burst is expanded into a list of future cycles.
    typedef struct packed {
        logic tone;
        logic freq;
    } slot_t;

    slot_t plan[$];
    logic  m_busy, m_tone, m_freq, m_done;

    // Observed statistics for the table-driven checks.
    int          busy_cycles, beeps, dones;
    logic [15:0] freq_bits;
    logic        prev_tone;

    function automatic logic beep_freq(input logic [1:0] p, input int k);
        case (p)
            2'b00:   return 1'b0;
            2'b01:   return 1'b1;
            2'b10:   return (k % 2) == 1;
            default: return (k % 2) == 0;
        endcase
    endfunction

    function automatic void model_reset();
        plan.delete();
        m_busy = 0; m_tone = 0; m_freq = 0; m_done = 0;
        prev_tone = 0;
    endfunction

    function automatic void model_edge(input logic s, input logic c,
                                       input logic [3:0] bc, input logic [1:0] p);
        slot_t sl;
        m_done = 0;
        if (m_busy) begin
            if (c) begin
                plan.delete();
                m_busy = 0; m_tone = 0;
            end else if (plan.size() == 0) begin
                m_busy = 0; m_tone = 0; m_done = 1;
            end else begin
                sl = plan.pop_front();
                m_tone = sl.tone; m_freq = sl.freq;
            end
        end else if (s && !c && bc != 0) begin
            for (int k = 0; k < int'(bc); k++) begin
                for (int i = 0; i < ON; i++) plan.push_back('{tone: 1'b1, freq: beep_freq(p, k)});
                if (k < int'(bc) - 1)
                    for (int i = 0; i < OFF; i++) plan.push_back('{tone: 1'b0, freq: beep_freq(p, k)});
            end
            sl = plan.pop_front();
            m_busy = 1; m_tone = sl.tone; m_freq = sl.freq;
        end
    endfunction

    function automatic void expect_val(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic step(input logic s, input logic c, input logic [3:0] bc, input logic [1:0] p);
        start = s; cancel = c; beep_count = bc; pattern = p;
        @(posedge clk);
        model_edge(s, c, bc, p);
        #1;
        expect_val("cycle {tone_on,tone_en,freq_sel,busy,done}",
                   int'({tone_on, tone_en, freq_sel, busy, done}),
                   int'({m_tone, m_busy, m_freq, m_busy, m_done}));
        if (busy) busy_cycles++;
        if (tone_on && !prev_tone) begin
            freq_bits[beeps] = freq_sel;
            beeps++;
        end
        prev_tone = tone_on;
        if (done) dones++;
        @(negedge clk);
    endtask

    task automatic clear_stats();
        busy_cycles = 0; beeps = 0; dones = 0; freq_bits = '0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (busy && g < 300) begin
            step(1'b0, 1'b0, 4'd0, 2'b00);
            g++;
        end
        expect_val("drain timeout", int'(busy), 0);
        step(1'b0, 1'b0, 4'd0, 2'b00);
    endtask

    typedef struct {
        logic [3:0]  bc;
        logic [1:0]  pat;
        int          cancel_at;
        int          exp_busy;
        int          exp_beeps;
        int          exp_done;
        logic [15:0] exp_freq;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int g;
        int idx;

        tbl[0] = '{bc: 4'd3,  pat: 2'b00, cancel_at: -1, exp_busy: 18,  exp_beeps: 3,  exp_done: 1, exp_freq: 16'h0000};
        tbl[1] = '{bc: 4'd4,  pat: 2'b10, cancel_at: -1, exp_busy: 25,  exp_beeps: 4,  exp_done: 1, exp_freq: 16'h000A};
        tbl[2] = '{bc: 4'd4,  pat: 2'b11, cancel_at: -1, exp_busy: 25,  exp_beeps: 4,  exp_done: 1, exp_freq: 16'h0005};
        tbl[3] = '{bc: 4'd4,  pat: 2'b01, cancel_at: -1, exp_busy: 25,  exp_beeps: 4,  exp_done: 1, exp_freq: 16'h000F};
        tbl[4] = '{bc: 4'd2,  pat: 2'b00, cancel_at: 5,  exp_busy: 6,   exp_beeps: 1,  exp_done: 0, exp_freq: 16'h0000};
        tbl[5] = '{bc: 4'd1,  pat: 2'b11, cancel_at: -1, exp_busy: 4,   exp_beeps: 1,  exp_done: 1, exp_freq: 16'h0001};
        tbl[6] = '{bc: 4'd15, pat: 2'b10, cancel_at: -1, exp_busy: 102, exp_beeps: 15, exp_done: 1, exp_freq: 16'h2AAA};

        rst = 1'b1; start = 0; cancel = 0; beep_count = '0; pattern = '0;
        model_reset();
        clear_stats();
        #1;
        expect_val("reset outputs", int'({tone_on, tone_en, freq_sel, busy, done}), 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // Burst scenarios from the table
        for (int v = 0; v < 7; v++) begin
            clear_stats();
            step(1'b1, 1'b0, tbl[v].bc, tbl[v].pat);
            idx = 0; g = 0;
            while (busy && g < 300) begin
                step(1'b0, idx == tbl[v].cancel_at, 4'($urandom), 2'($urandom));
                idx++; g++;
            end
            expect_val($sformatf("vec%0d timeout", v), int'(busy), 0);
            step(1'b0, 1'b0, 4'd0, 2'b00);
            step(1'b0, 1'b0, 4'd0, 2'b00);
            expect_val($sformatf("vec%0d busy cycles", v), busy_cycles, tbl[v].exp_busy);
            expect_val($sformatf("vec%0d beeps", v), beeps, tbl[v].exp_beeps);
            expect_val($sformatf("vec%0d done pulses", v), dones, tbl[v].exp_done);
            expect_val($sformatf("vec%0d freq per beep", v), int'(freq_bits), int'(tbl[v].exp_freq));
        end

        // Zero beep count and start+cancel are both dropped
        clear_stats();
        step(1'b1, 1'b0, 4'd0, 2'b01);
        step(1'b0, 1'b0, 4'd0, 2'b01);
        step(1'b1, 1'b1, 4'd3, 2'b00);
        step(1'b0, 1'b0, 4'd3, 2'b00);
        expect_val("ignored starts busy", busy_cycles, 0);
        expect_val("ignored starts done", dones, 0);

        // Repeated starts during a burst are ignored
        clear_stats();
        step(1'b1, 1'b0, 4'd2, 2'b00);
        g = 0;
        while (busy && g < 100) begin
            step(1'b1, 1'b0, 4'd5, 2'b11);
            g++;
        end
        expect_val("restart ignored beeps", beeps, 2);
        expect_val("restart ignored done", dones, 1);
        step(1'b0, 1'b0, 4'd0, 2'b00);

        // Start in the done cycle begins a new burst immediately
        step(1'b1, 1'b0, 4'd1, 2'b00);
        g = 0;
        while (!done && g < 100) begin
            step(1'b0, 1'b0, 4'd0, 2'b00);
            g++;
        end
        expect_val("done seen", int'(done), 1);
        step(1'b1, 1'b0, 4'd2, 2'b01);
        expect_val("back-to-back tone_on", int'(tone_on), 1);
        expect_val("back-to-back freq_sel", int'(freq_sel), 1);
        drain();

        // Asynchronous reset in the middle of an ON period
        step(1'b1, 1'b0, 4'd3, 2'b00);
        step(1'b0, 1'b0, 4'd3, 2'b00);
        step(1'b0, 1'b0, 4'd3, 2'b00);
        #2 rst = 1'b1;
        #1;
        expect_val("async reset {tone_on,tone_en,busy}", int'({tone_on, tone_en, busy}), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 1'b0, 4'd0, 2'b00);
        step(1'b1, 1'b0, 4'd2, 2'b11);
        expect_val("post-reset start tone_on", int'(tone_on), 1);
        drain();

        // Random traffic against the model
        for (int b = 0; b < 30; b++) begin
            step(1'b1, $urandom_range(0, 7) == 0, 4'($urandom_range(0, 5)), 2'($urandom));
            for (int k = 0; k < 80 && (busy || k < 2); k++) begin
                step($urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0,
                     4'($urandom_range(0, 5)), 2'($urandom));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/beep_pattern_sequencer.md
Name: beep_pattern_sequencer

Overview:
Upstream control stage for the square-wave tone generator. On a start pulse it plays a burst of N beeps with fixed on/off durations, driving the generator's tone request, enable and frequency-select inputs. Beep count and frequency pattern are latched at start. The block runs from the system clock and counts cycles directly; there is no prescaler.

Parameters:
ON_TICKS, 25000000, clock cycles tone_on stays high per beep (must be >= 1)
OFF_TICKS, 12500000, clock cycles of silence between consecutive beeps (must be >= 1)
TIMER_W, 32, width of the duration down-counter (must hold max(ON_TICKS, OFF_TICKS) - 1)
CNT_W, 4, width of beep_count

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  single-cycle request to begin a burst; sampled only in IDLE
cancel  input  1  abort the current burst
beep_count  input  CNT_W  number of beeps, latched on accepted start
pattern  input  2  frequency pattern: 00 all high-freq, 01 all low-freq, 10 alternate starting high, 11 alternate starting low
tone_on  output  1  tone request to the generator's "in" input
tone_en  output  1  generator enable; high while busy
freq_sel  output  1  to generator freqSel; 0 = high frequency, 1 = low frequency
busy  output  1  burst in progress
done  output  1  one-cycle pulse when a burst completes normally

Behaviour:
- All outputs are registered. Reset (asynchronous, rst=1): state=IDLE; tone_on, tone_en, freq_sel, busy and done are 0; timer and remaining are 0.
- States: IDLE, ON, OFF.
- IDLE:
  - When start=1, cancel=0 and beep_count!=0 at a clock edge:
    - Next state is ON, with tone_on=1, busy=1, tone_en=1.
    - timer loads ON_TICKS-1; remaining loads beep_count-1.
    - freq_sel = pattern[0]; pattern is latched.
  - When beep_count==0, start is ignored: no busy, no done.
- ON, at each edge:
  - If timer!=0, timer decrements.
  - If timer==0 and remaining==0: go to IDLE; tone_on, busy and tone_en go to 0; done=1 for exactly one cycle.
  - If timer==0 and remaining!=0: go to OFF; tone_on=0; timer loads OFF_TICKS-1.
- OFF, at each edge:
  - If timer!=0, timer decrements.
  - If timer==0: go to ON; tone_on=1; remaining decrements; timer loads ON_TICKS-1.
  - On this transition freq_sel toggles when latched pattern[1]=1, and holds otherwise.
- Timing:
  - tone_on is high for exactly ON_TICKS cycles per beep and low for exactly OFF_TICKS cycles between beeps.
  - Latency from the start edge to tone_on=1 is one edge (visible in the cycle after start is sampled).
  - busy spans N*ON_TICKS + (N-1)*OFF_TICKS cycles.
- start while busy is ignored. beep_count and pattern changes while busy have no effect.
- cancel=1 in ON or OFF: at the next edge go to IDLE with tone_on, tone_en and busy all 0; no done pulse.
- cancel=1 in IDLE: no effect. cancel and start in the same IDLE cycle: cancel wins and start is dropped.
- done is high only in the first IDLE cycle after normal completion. A start in that same cycle is accepted (back-to-back bursts).
- Reset asserted mid-burst returns everything to reset values immediately and asynchronously.
- Counter arithmetic: unsigned, no wrap. Decrement occurs only when the value is nonzero.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE=2'd0, ST_ON=2'd1, ST_OFF=2'd2;
  - pattern codes PAT_HIGH, PAT_LOW, PAT_ALT_H, PAT_ALT_L;
  - FREQ_SEL_HIGH=1'b0, FREQ_SEL_LOW=1'b1, also used by the tone generator.
- One natural sub-module: sequencer_timer, a loadable down-counter with a zero flag, width TIMER_W, inputs load, load_val and dec.
- The FSM and beep counter stay in the top module.

Test Plan (ON_TICKS=4, OFF_TICKS=3):
1. Reset, then start with beep_count=3, pattern=00 -> tone_on pattern 1111 000 1111 000 1111; freq_sel=0 throughout; busy high for 18 cycles; done pulses once in the cycle after busy falls.
2. beep_count=4, pattern=10 -> freq_sel per beep 0,1,0,1. With pattern=11 -> 1,0,1,0. With pattern=01 -> constantly 1.
3. Start with beep_count=2; assert cancel in the 2nd cycle of the first OFF gap -> next cycle busy=tone_on=tone_en=0; done never asserts; no second beep.
4. Start pulse with beep_count=0 -> busy stays 0 and no outputs change. Start and cancel together in IDLE -> no burst.
5. Second start pulses during a burst (beep_count=2) -> ignored; exactly 2 beeps occur. Start in the done cycle -> new burst begins, tone_on high the next cycle.
6. Assert rst in the middle of an ON period -> tone_on, busy and tone_en drop asynchronously before the next clock edge. After release, the block is idle and accepts a fresh start.
